// File: rtl/apb3_slave_regfile.sv
// APB3 completer: NREGS read/write registers plus a read-only transfer counter.
// Optional wait states are built when APB_SLV_WAIT_EN is defined.
module apb3_slave_regfile #(
   parameter int DSIZE       = 32,
   parameter int AW          = 12,
   parameter int NREGS       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             pclk,
   input  logic             prst_n,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [AW-1:0]    paddr,
   input  logic [DSIZE-1:0] pwdata,
   output logic [DSIZE-1:0] prdata,
   output logic             pready,
   output logic             pslverr
);

   localparam int LP_XW = AW - 2;
   localparam int LP_IW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [LP_XW-1:0] LP_CNT_IDX = LP_XW'(NREGS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_pready;
   logic [DSIZE-1:0] r_prdata;
   logic             r_pslverr;
   logic             w_pready_nxt;
   logic [DSIZE-1:0] w_prdata_nxt;
   logic             w_pslverr_nxt;
   logic             w_commit;

   logic [DSIZE-1:0] r_regs [NREGS];
   logic [DSIZE-1:0] r_xfer_cnt;

   logic [LP_IW-1:0] r_widx;
   logic             r_write;
   logic [DSIZE-1:0] r_wdata;
   logic             r_is_reg;

   logic [LP_XW-1:0] w_idx;
   logic             w_aligned;
   logic             w_dec_reg;
   logic             w_dec_cnt;
   logic             w_dec_err;
   logic [DSIZE-1:0] w_dec_rdata;
   logic             w_setup;

   assign prdata  = r_prdata;
   assign pready  = r_pready;
   assign pslverr = r_pslverr;

   // Address decode works on the live bus so the setup cycle can latch its result
   assign w_idx       = paddr[AW-1:2];
   assign w_aligned   = (paddr[1:0] == 2'b00);
   assign w_dec_reg   = w_aligned && (w_idx < LP_CNT_IDX);
   assign w_dec_cnt   = w_aligned && (w_idx == LP_CNT_IDX);
   assign w_dec_err   = ~(w_dec_reg | (w_dec_cnt & ~pwrite));
   assign w_dec_rdata = pwrite    ? '0 :
                        w_dec_reg ? r_regs[w_idx[LP_IW-1:0]] :
                        w_dec_cnt ? r_xfer_cnt : '0;
   assign w_setup     = (r_state == S_IDLE) & psel & ~penable;

`ifdef APB_SLV_WAIT_EN
   localparam int LP_WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   logic [LP_WCW-1:0] r_wcnt;
   logic [LP_WCW-1:0] w_wcnt_nxt;
   logic [DSIZE-1:0]  r_rd_hold;
   logic              r_err;

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         r_wcnt <= '0;
      end else begin
         r_wcnt <= w_wcnt_nxt;
      end
   end

   // Read data is captured at setup so a stalled read returns the setup-time value
   always_ff @(posedge pclk) begin
      if (w_setup) begin
         r_rd_hold <= w_dec_rdata;
         r_err     <= w_dec_err;
      end
   end
`else
   logic w_unused_wait;
   assign w_unused_wait = (WAIT_CYCLES != 0);
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_pready_nxt  = 1'b0;
      w_prdata_nxt  = '0;
      w_pslverr_nxt = 1'b0;
      w_commit      = 1'b0;
`ifdef APB_SLV_WAIT_EN
      w_wcnt_nxt    = r_wcnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_setup) begin
`ifdef APB_SLV_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  w_state_nxt = S_WAIT;
                  w_wcnt_nxt  = LP_WCW'(WAIT_CYCLES);
               end else begin
                  w_state_nxt   = S_ACCESS;
                  w_pready_nxt  = 1'b1;
                  w_prdata_nxt  = w_dec_rdata;
                  w_pslverr_nxt = w_dec_err;
               end
`else
               w_state_nxt   = S_ACCESS;
               w_pready_nxt  = 1'b1;
               w_prdata_nxt  = w_dec_rdata;
               w_pslverr_nxt = w_dec_err;
`endif
            end
         end
`ifdef APB_SLV_WAIT_EN
         S_WAIT: begin
            if (!psel) begin
               w_state_nxt = S_IDLE;
            end else if (r_wcnt == LP_WCW'(1)) begin
               w_state_nxt   = S_ACCESS;
               w_pready_nxt  = 1'b1;
               w_prdata_nxt  = r_rd_hold;
               w_pslverr_nxt = r_err;
            end else begin
               w_wcnt_nxt = r_wcnt - LP_WCW'(1);
            end
         end
`endif
         S_ACCESS: begin
            w_state_nxt = S_IDLE;
            w_commit    = psel & penable;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         r_state   <= S_IDLE;
         r_pready  <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pready  <= w_pready_nxt;
         r_prdata  <= w_prdata_nxt;
         r_pslverr <= w_pslverr_nxt;
      end
   end

   always_ff @(posedge pclk) begin
      if (w_setup) begin
         r_widx   <= w_idx[LP_IW-1:0];
         r_write  <= pwrite;
         r_wdata  <= pwdata;
         r_is_reg <= w_dec_reg;
      end
   end

   // Errored transfers still count; only legal RW targets accept write data
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_xfer_cnt <= '0;
      end else if (w_commit) begin
         r_xfer_cnt <= r_xfer_cnt + DSIZE'(1);
         if (r_write && r_is_reg) begin
            r_regs[r_widx] <= r_wdata;
         end
      end
   end

endmodule

// File: tb/tb_apb3_slave_regfile.sv
// Bench for apb3_slave_regfile: directed vector table, corner sequences and
// random transfers checked against a word-array model of the register map.
module tb_apb3_slave_regfile;

   logic        pclk    = 1'b0;
   logic        prst_n  = 1'b1;
   logic        psel    = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [11:0] paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

`ifdef APB_SLV_WAIT_EN
   localparam logic [31:0] LP_WAIT = 32'd2;
`else
   localparam logic [31:0] LP_WAIT = 32'd0;
`endif

   apb3_slave_regfile #(
      .DSIZE(32), .AW(12), .NREGS(16), .WAIT_CYCLES(2)
   ) dut (
      .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_regs [16];
   logic [31:0] m_cnt;

   typedef struct {
      bit          rst;
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   function automatic void mdl_clear();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_cnt = '0;
   endfunction

   function automatic void mdl(input logic [11:0] a, input logic w, input logic [31:0] d,
                               output logic [31:0] rd, output logic er);
      int unsigned idx;
      idx = {20'b0, a} >> 2;
      rd  = '0;
      er  = 1'b0;
      if (a[1:0] != 2'b00 || idx > 16) er = 1'b1;
      else if (idx == 16) begin
         if (w) er = 1'b1;
         else   rd = m_cnt;
      end
      else if (w) m_regs[idx] = d;
      else        rd = m_regs[idx];
      m_cnt = m_cnt + 32'd1;
   endfunction

   task automatic do_reset();
      prst_n  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      #1;
      chk("reset pready", {31'b0, pready}, 32'd0);
      chk("reset pslverr", {31'b0, pslverr}, 32'd0);
      chk("reset prdata", prdata, 32'd0);
      repeat (2) @(posedge pclk);
      #1;
      prst_n = 1'b1;
      mdl_clear();
      @(posedge pclk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the completion edge
   task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int nw);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      nw = 0;
      while (pready !== 1'b1 && nw < 20) begin
         @(posedge pclk);
         #1;
         nw++;
      end
      rd = prdata;
      er = pslverr;
      @(posedge pclk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic run_chk(input string nm, input logic [11:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] erd, input logic eer);
      logic [31:0] rd;
      logic        er;
      int          nw;
      xfer(a, w, d, rd, er, nw);
      chk({nm, " wait"}, 32'(nw), LP_WAIT);
      chk({nm, " pslverr"}, {31'b0, er}, {31'b0, eer});
      if (!w) chk({nm, " prdata"}, rd, erd);
      chk({nm, " pready_after"}, {31'b0, pready}, 32'd0);
      chk({nm, " prdata_after"}, prdata, 32'd0);
   endtask

   task automatic model_xfer(input string nm, input logic [11:0] a, input logic w,
                             input logic [31:0] d);
      logic [31:0] erd;
      logic        eer;
      mdl(a, w, d, erd, eer);
      run_chk(nm, a, w, d, erd, eer);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] dmy_rd;
      logic        dmy_er;
      logic [11:0] a;
      logic        w;
      logic [31:0] d;

      tbl[0] = '{1'b1, 12'h040, 1'b0, 32'h0,         32'h0,         1'b0};
      tbl[1] = '{1'b0, 12'h000, 1'b0, 32'h0,         32'h0,         1'b0};
      tbl[2] = '{1'b1, 12'h008, 1'b1, 32'hDEADBEEF,  32'h0,         1'b0};
      tbl[3] = '{1'b0, 12'h008, 1'b0, 32'h0,         32'hDEADBEEF,  1'b0};
      tbl[4] = '{1'b0, 12'h040, 1'b0, 32'h0,         32'd2,         1'b0};
      tbl[5] = '{1'b1, 12'h040, 1'b1, 32'h12345678,  32'h0,         1'b1};
      tbl[6] = '{1'b0, 12'h044, 1'b0, 32'h0,         32'h0,         1'b1};
      tbl[7] = '{1'b0, 12'h002, 1'b0, 32'h0,         32'h0,         1'b1};
      tbl[8] = '{1'b0, 12'h040, 1'b0, 32'h0,         32'd3,         1'b0};
      tbl[9] = '{1'b0, 12'h03C, 1'b0, 32'h0,         32'h0,         1'b0};

      mdl_clear();
      #2;
      do_reset();

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) do_reset();
         mdl(tbl[i].addr, tbl[i].wr, tbl[i].wdata, dmy_rd, dmy_er);
         run_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata,
                 tbl[i].exp_rd, tbl[i].exp_err);
      end

      // psel withdrawn after setup: no write lands and the counter holds
      do_reset();
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 12'h010;
      pwrite  = 1'b1;
      pwdata  = 32'hCAFEF00D;
      @(posedge pclk);
      #1;
      psel = 1'b0;
`ifdef APB_SLV_WAIT_EN
      begin
         int npr;
         npr = 0;
         repeat (4) begin
            if (pready) npr++;
            @(posedge pclk);
            #1;
         end
         chk("abort pready_seen", 32'(npr), 32'd0);
      end
`else
      repeat (4) @(posedge pclk);
      #1;
`endif
      model_xfer("abort reg", 12'h010, 1'b0, 32'h0);
      model_xfer("abort cnt", 12'h040, 1'b0, 32'h0);

      // Counter wrap
      force dut.r_xfer_cnt = 32'hFFFFFFFF;
      #1;
      release dut.r_xfer_cnt;
      m_cnt = 32'hFFFFFFFF;
      model_xfer("wrap max", 12'h040, 1'b0, 32'h0);
      model_xfer("wrap zero", 12'h040, 1'b0, 32'h0);

      // Back-to-back fill of the whole register bank, then readback
      for (int i = 0; i < 16; i++)
         model_xfer($sformatf("b2b wr%0d", i), 12'(i * 4), 1'b1,
                    (32'(i) + 32'd1) * 32'h01010101 ^ 32'hA5000000);
      for (int i = 0; i < 16; i++)
         model_xfer($sformatf("b2b rd%0d", i), 12'(i * 4), 1'b0, 32'h0);

      // Reset asserted while a write to 0x0C is in its access cycle
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 12'h00C;
      pwrite  = 1'b1;
      pwdata  = 32'hA5A5A5A5;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      for (int n = 0; n < 20 && pready !== 1'b1; n++) begin
         @(posedge pclk);
         #1;
      end
      chk("rstmid in_access", {31'b0, pready}, 32'd1);
      #2;
      prst_n = 1'b0;
      #1;
      chk("rstmid pready", {31'b0, pready}, 32'd0);
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
      prst_n = 1'b1;
      mdl_clear();
      @(posedge pclk);
      #1;
      model_xfer("rstmid reg3", 12'h00C, 1'b0, 32'h0);
      model_xfer("rstmid cnt", 12'h040, 1'b0, 32'h0);

      // Random traffic with occasional idle gaps
      for (int k = 0; k < 300; k++) begin
         a = 12'($urandom_range(0, 19) * 4);
         if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) a = 12'($urandom_range(0, 4095));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         model_xfer($sformatf("rnd%0d", k), a, w, d);
         repeat ($urandom_range(0, 2)) @(posedge pclk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
